// File: rtl/stride_prefetch_gen_pkg.sv
// prefetch_pkg: shared constants and types for the stride prefetch
// generator slice.
//   LINE_OFFSET_W / PAGE_OFFSET_W : byte-offset widths of a line / page
//   line_addr_t                   : 27-bit line address (byte addr >> 5)
//   pf_train_e                    : stride training FSM states
package prefetch_pkg;

    localparam int unsigned LINE_OFFSET_W = 5;
    localparam int unsigned PAGE_OFFSET_W = 12;
    localparam int unsigned LINE_ADDR_W   = 32 - LINE_OFFSET_W;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TRAINING,
        STEADY
    } pf_train_e;

endpackage

// File: rtl/stride_prefetch_gen_if.sv
// stride_prefetch_gen_if: groups the L2 snoop inputs, flush, the
// prefetcher handshake and the drop counter of stride_prefetch_gen.
//   master : drives L2 snoop / flush / pf_ready, observes ORB side
//   slave  : the generator itself
interface stride_prefetch_gen_if;

    logic [31:0] L2_req_address;
    logic        L2_req_read;
    logic        L2_req_resp;
    logic        pf_flush;
    logic        pf_ready;
    logic [31:0] ORB;
    logic        prefetch_en;
    logic [15:0] pf_drop_count;

    modport master (
        output L2_req_address,
        output L2_req_read,
        output L2_req_resp,
        output pf_flush,
        output pf_ready,
        input  ORB,
        input  prefetch_en,
        input  pf_drop_count
    );

    modport slave (
        input  L2_req_address,
        input  L2_req_read,
        input  L2_req_resp,
        input  pf_flush,
        input  pf_ready,
        output ORB,
        output prefetch_en,
        output pf_drop_count
    );

endinterface

// File: rtl/stride_prefetch_gen_fifo.sv
// pf_addr_fifo: synchronous candidate-address FIFO, DEPTH entries
// (power of two, >= 2) of WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   flush      : synchronous clear, wins over push/pop
//   push, din  : enqueue; accepted when not full, or full with a pop
//   pop        : dequeue head (ignored when empty)
//   dout       : head entry, zero while empty
//   full/empty : occupancy flags
module pf_addr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stride_prefetch_gen.sv
// stride_prefetch_gen: snoops completed L2 demand reads, learns one
// constant line stride with a saturating 0..3 confidence counter and,
// once confident, queues predicted line addresses for the prefetcher.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.L2_req_address/L2_req_read/L2_req_resp : demand snoop
//   bus.pf_flush      : clear training state and queue
//   bus.pf_ready      : prefetcher accepts ORB this cycle
//   bus.ORB           : candidate line address (queue head)
//   bus.prefetch_en   : ORB valid
//   bus.pf_drop_count : saturating count of candidates lost to a full queue
// Build option PF_PAGE_BOUND_EN: discard candidates that leave the 4 KiB
// page of the triggering request (not counted as drops).
module stride_prefetch_gen
    import prefetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STRIDE_W    = 8,
    parameter int unsigned CONF_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stride_prefetch_gen_if.slave  bus
);

    // Thresholds above 3 can never be reached by the 2-bit counter.
    localparam logic [2:0] THRESH_L = (CONF_THRESH > 3) ? 3'd4 : 3'(CONF_THRESH);

    pf_train_e                   state_q, state_d;
    logic signed [STRIDE_W-1:0]  stride_q, stride_d;
    logic [1:0]                  conf_q, conf_d;
    line_addr_t                  last_q, last_d;
    logic [31:0]                 last_enq_q;
    logic                        last_enq_vld_q;
    logic [15:0]                 drop_cnt_q;

    logic                        ev;
    line_addr_t                  ev_line;
    line_addr_t                  delta;
    logic [LINE_ADDR_W-STRIDE_W:0] delta_hi;
    logic                        in_range;
    logic [STRIDE_W-1:0]         delta_s;
    logic                        cand_gen;
    line_addr_t                  cand_line;
    logic [31:0]                 cand_addr;
    logic                        page_ok;
    logic                        dup_hit;
    logic                        cand_ok;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        push;
    logic                        drop;
    logic [31:0]                 fifo_head;

    assign ev       = bus.L2_req_read && bus.L2_req_resp;
    assign ev_line  = bus.L2_req_address[31:LINE_OFFSET_W];
    assign delta    = ev_line - last_q;
    // In range of a signed STRIDE_W value iff all bits from the sign bit
    // upward agree.
    assign delta_hi = delta[LINE_ADDR_W-1:STRIDE_W-1];
    assign in_range = (&delta_hi) || !(|delta_hi);
    assign delta_s  = delta[STRIDE_W-1:0];

    always_comb begin
        state_d  = state_q;
        stride_d = stride_q;
        conf_d   = conf_q;
        last_d   = last_q;
        cand_gen = 1'b0;
        if (ev) begin
            if (state_q == EMPTY) begin
                last_d  = ev_line;
                state_d = ONE;
            end else if (delta == '0) begin
                // repeated line: no training update
            end else if (!in_range) begin
                stride_d = '0;
                conf_d   = '0;
                last_d   = ev_line;
                state_d  = ONE;
            end else begin
                last_d = ev_line;
                if (state_q == ONE || delta_s != stride_q) begin
                    stride_d = delta_s;
                    conf_d   = '0;
                end else begin
                    conf_d = (conf_q == 2'd3) ? 2'd3 : conf_q + 2'd1;
                end
                cand_gen = ({1'b0, conf_d} >= THRESH_L);
                state_d  = cand_gen ? STEADY : TRAINING;
            end
        end
    end

    assign cand_line = ev_line + {{(LINE_ADDR_W-STRIDE_W){stride_d[STRIDE_W-1]}}, stride_d};
    assign cand_addr = {cand_line, {LINE_OFFSET_W{1'b0}}};

`ifdef PF_PAGE_BOUND_EN
    assign page_ok = (cand_addr[31:PAGE_OFFSET_W] == bus.L2_req_address[31:PAGE_OFFSET_W]);
`else
    assign page_ok = 1'b1;
`endif

    assign dup_hit = last_enq_vld_q && (cand_addr == last_enq_q);
    assign cand_ok = cand_gen && page_ok && !dup_hit && !bus.pf_flush;
    assign pop     = !fifo_empty && bus.pf_ready && !bus.pf_flush;
    assign push    = cand_ok && (!fifo_full || pop);
    assign drop    = cand_ok && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            stride_q       <= '0;
            conf_q         <= '0;
            last_q         <= '0;
            last_enq_q     <= '0;
            last_enq_vld_q <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            if (bus.pf_flush) begin
                state_q        <= EMPTY;
                stride_q       <= '0;
                conf_q         <= '0;
                last_enq_vld_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                stride_q <= stride_d;
                conf_q   <= conf_d;
                last_q   <= last_d;
                if (push) begin
                    last_enq_q     <= cand_addr;
                    last_enq_vld_q <= 1'b1;
                end
            end
            if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    pf_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.pf_flush),
        .push  (push),
        .din   (cand_addr),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.ORB           = fifo_head;
    assign bus.prefetch_en   = !fifo_empty;
    assign bus.pf_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_stride_prefetch_gen.sv
// Bench for stride_prefetch_gen: table of demand events with expected
// queue head, scoreboard of expected prefetcher handshakes, plus
// hand-written full-queue, flush and asynchronous-reset sequences.
// Honours PF_PAGE_BOUND_EN for the page-crossing expectation.
module tb_stride_prefetch_gen;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        resp;
        logic        flush;
        logic        ready;
        logic        exp_en;
        logic [31:0] exp_orb;
        logic        sb_push;
        logic [31:0] sb_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stride_prefetch_gen_if bus();

    stride_prefetch_gen #(
        .FIFO_DEPTH  (4),
        .STRIDE_W    (8),
        .CONF_THRESH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q [$];
    vec_t        tbl [$];
    logic        held = 1'b0;
    logic [31:0] held_orb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] addr, input logic rd, input logic resp,
                               input logic flush, input logic ready, input logic exp_en,
                               input logic [31:0] exp_orb, input logic sb_push,
                               input logic [31:0] sb_val);
        vec_t r;
        r.addr = addr; r.rd = rd; r.resp = resp; r.flush = flush; r.ready = ready;
        r.exp_en = exp_en; r.exp_orb = exp_orb; r.sb_push = sb_push; r.sb_val = sb_val;
        return r;
    endfunction

    function automatic vec_t ev(input logic [31:0] addr, input logic exp_en, input logic [31:0] exp_orb);
        return v(addr, 1'b1, 1'b1, 1'b0, 1'b1, exp_en, exp_orb, exp_en, exp_orb);
    endfunction

    function automatic vec_t fl();
        return v(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input vec_t t, input string name);
        bus.L2_req_address = t.addr;
        bus.L2_req_read    = t.rd;
        bus.L2_req_resp    = t.resp;
        bus.pf_flush       = t.flush;
        bus.pf_ready       = t.ready;
        if (t.sb_push) exp_q.push_back(t.sb_val);
        tick();
        bus.L2_req_read = 1'b0;
        bus.L2_req_resp = 1'b0;
        bus.pf_flush    = 1'b0;
        @(negedge clk);
        check({name, ".en"}, {31'b0, bus.prefetch_en}, {31'b0, t.exp_en});
        if (t.exp_en) check({name, ".orb"}, bus.ORB, t.exp_orb);
        tick();
    endtask

    // Handshake monitor and head-stability check.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && bus.prefetch_en) check("orb_stable", bus.ORB, held_orb);
            if (bus.prefetch_en && bus.pf_ready && !bus.pf_flush) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL handshake: ORB 0x%08h presented, no candidate expected", bus.ORB);
                end else begin
                    check("handshake", bus.ORB, exp_q.pop_front());
                end
            end
            held     = bus.prefetch_en && !bus.pf_ready && !bus.pf_flush;
            held_orb = bus.ORB;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] drain [3];
        bus.L2_req_address = '0;
        bus.L2_req_read    = 1'b0;
        bus.L2_req_resp    = 1'b0;
        bus.pf_flush       = 1'b0;
        bus.pf_ready       = 1'b1;
        rst_n              = 1'b0;

        // positive stride, write ignored, repeat line ignored
        tbl.push_back(ev(32'h1000, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1020, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1040, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1060, 1'b1, 32'h1080));
        tbl.push_back(v(32'h1080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1080, 1'b1, 32'h10A0));
        tbl.push_back(ev(32'h1080, 1'b0, 32'h0));
        tbl.push_back(fl());
        // negative stride
        tbl.push_back(ev(32'h2300, 1'b0, 32'h0));
        tbl.push_back(ev(32'h22C0, 1'b0, 32'h0));
        tbl.push_back(ev(32'h2280, 1'b0, 32'h0));
        tbl.push_back(ev(32'h2240, 1'b1, 32'h2200));
        // out-of-range jump retrains from ONE
        tbl.push_back(ev(32'h8_0000, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_0020, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_0040, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_0060, 1'b1, 32'h8_0080));
        // +128 lines is out of range, +127 lines is the largest stride
        tbl.push_back(ev(32'h8_1060, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_2040, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_3020, 1'b0, 32'h0));
        tbl.push_back(ev(32'h8_4000, 1'b1, 32'h8_4FE0));
        tbl.push_back(fl());
        // page crossing candidate
        tbl.push_back(ev(32'h1F80, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1FA0, 1'b0, 32'h0));
        tbl.push_back(ev(32'h1FC0, 1'b0, 32'h0));
`ifdef PF_PAGE_BOUND_EN
        tbl.push_back(ev(32'h1FE0, 1'b0, 32'h0));
`else
        tbl.push_back(ev(32'h1FE0, 1'b1, 32'h2000));
`endif

        // reset values, asserted and after release
        #23;
        check("rst.en",   {31'b0, bus.prefetch_en}, 32'h0);
        check("rst.orb",  bus.ORB, 32'h0);
        check("rst.drop", {16'b0, bus.pf_drop_count}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("post_rst.en",   {31'b0, bus.prefetch_en}, 32'h0);
        check("post_rst.orb",  bus.ORB, 32'h0);
        check("post_rst.drop", {16'b0, bus.pf_drop_count}, 32'h0);
        tick();

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // full queue: 6 candidates, 4 kept, 2 dropped
        step(v(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), "fq.flush");
        for (int i = 0; i < 9; i++) begin
            step(v(32'h4000 + 32'(i) * 32'h20, 1'b1, 1'b1, 1'b0, 1'b0,
                   (i >= 3), 32'h4080, (i >= 3 && i <= 6), 32'h4000 + 32'(i + 1) * 32'h20),
                 $sformatf("fq.ev%0d", i));
        end
        check("fq.drop", {16'b0, bus.pf_drop_count}, 32'd2);
        // full with a dequeue in the same cycle: enqueue succeeds
        step(v(32'h4120, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40A0, 1'b1, 32'h4140), "fq.same");
        drain[0] = 32'h40C0;
        drain[1] = 32'h40E0;
        drain[2] = 32'h4140;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fq.drain%0d.en", i), {31'b0, bus.prefetch_en}, 32'h1);
            check($sformatf("fq.drain%0d.orb", i), bus.ORB, drain[i]);
        end
        @(negedge clk);
        check("fq.drained.en", {31'b0, bus.prefetch_en}, 32'h0);
        check("fq.drop2", {16'b0, bus.pf_drop_count}, 32'd2);
        tick();

        // flush with two queued entries and a simultaneous event/dequeue
        step(v(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), "fl.pre");
        step(v(32'h6000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), "fl.ev0");
        step(v(32'h6020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), "fl.ev1");
        step(v(32'h6040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), "fl.ev2");
        step(v(32'h6060, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6080, 1'b0, 32'h0), "fl.ev3");
        step(v(32'h6080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6080, 1'b0, 32'h0), "fl.ev4");
        step(v(32'h60A0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0), "fl.flush");
        step(ev(32'h60C0, 1'b0, 32'h0), "fl.re0");
        step(ev(32'h60E0, 1'b0, 32'h0), "fl.re1");
        step(ev(32'h6100, 1'b0, 32'h0), "fl.re2");
        step(ev(32'h6120, 1'b1, 32'h6140), "fl.re3");
        check("fl.drop_kept", {16'b0, bus.pf_drop_count}, 32'd2);

        // asynchronous reset with an entry queued
        step(v(32'h6140, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6160, 1'b0, 32'h0), "ar.ev");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.en",   {31'b0, bus.prefetch_en}, 32'h0);
        check("ar.orb",  bus.ORB, 32'h0);
        check("ar.drop", {16'b0, bus.pf_drop_count}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("ar.after.en", {31'b0, bus.prefetch_en}, 32'h0);
        check("sb.remaining", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
